note_tracker: RTL and testbench
===============================

Name: note_tracker

Overview:
- Consumes per-frame dominant FFT bin indices from the peak finder (one `peak_valid_in` pulse per FFT frame).
- Debounces them into stable note events: note_on when a bin persists, note_off when it is lost.
- note_off carries the held duration in frames.
- Sits between the peak finder and the transcription/MIDI formatting stage.

Parameters:
- STABLE_FRAMES, 3, consecutive matching frames required to declare note_on (>=1)
- RELEASE_FRAMES, 2, consecutive non-matching frames required to declare note_off (>=1)
- BIN_TOL, 1, max |bin difference| counted as the same note
- MIN_BIN, 2, bins below this are silence
- MAX_BIN, 299, bins above this are silence

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-high
- peak_in  input  12  dominant bin index of the latest frame
- peak_valid_in  input  1  one-cycle strobe, `peak_in` valid
- event_valid_out  output  1  one-cycle event strobe
- event_type_out  output  1  1 = note_on, 0 = note_off
- event_bin_out  output  12  bin of the note the event refers to
- event_dur_out  output  16  duration in frames (note_off); 0 on note_on

Behaviour:
- Reset (async, active-high): state = IDLE; all counters 0; all outputs 0; pending flag cleared. No event is emitted for a note interrupted by reset.
- silent(b) = b < MIN_BIN or b > MAX_BIN. A bin of 4095 is therefore silent.
- match(a,b) = |a-b| <= BIN_TOL, computed unsigned with a 13-bit difference.
- All decisions occur only on cycles with `peak_valid_in` = 1; otherwise state holds.
- Event outputs are registered: asserted the cycle after the deciding `peak_valid_in`, for exactly one cycle.
- IDLE:
  - non-silent: cand_bin <= peak, cand_cnt <= 1, go to CAND.
  - If STABLE_FRAMES == 1, go straight to ACTIVE and emit note_on.
  - silent: stay.
- CAND:
  - match(peak, cand_bin): cand_cnt++.
  - When it reaches STABLE_FRAMES: go to ACTIVE, act_bin <= cand_bin, dur <= STABLE_FRAMES, miss_cnt <= 0, emit note_on(cand_bin).
  - non-matching non-silent: restart the candidate with the new bin, cnt = 1.
  - silent: go to IDLE, no event.
- ACTIVE:
  - match(peak, act_bin): dur <= sat_inc(dur) (saturates at 16'hFFFF); miss_cnt <= 0.
  - otherwise: miss_cnt++. Miss frames do not add to dur.
  - When miss_cnt reaches RELEASE_FRAMES: emit note_off(act_bin, dur).
  - After note_off with a non-silent current peak: go to CAND (cnt = 1); with a silent current peak: go to IDLE.
- Simultaneous events (STABLE_FRAMES == 1 and release on a non-silent frame):
  - note_off is emitted first.
  - note_on for the new bin is held in a pending register and emitted the following cycle.
  - A `peak_valid_in` arriving on that following cycle is processed normally. Its event, if any, is queued behind the pending one, which emits one cycle later; no event is dropped.
- `act_bin` is not updated by tolerance matches; a slow drift beyond BIN_TOL counts as misses.

Optional Feature:
- Macro `NOTE_TRACKER_HOLD_OUT_EN`.
- Defined: adds two output ports.
  - `note_active_out` (1): high while state = ACTIVE, including miss frames.
  - `note_bin_out` (12): act_bin while active, else 0.
  - Both are registered and reset to 0, so downstream display logic can read the current note without tracking events.
- Undefined: the ports and their registers are absent; event behaviour is identical.

Test Plan:
- Assert `rst_in` mid-cycle with no clock edge -> all outputs 0 immediately; `peak_in` = 40 ×2 after release -> no event.
- Frames 40, 40, 41 -> single note_on, bin 40, dur 0, one cycle after the third strobe; no other events.
- Note active at 40, then 40 ×5, then 0, 0 -> note_off bin 40, dur 8 after the second silent frame; state IDLE.
- Active at 40, frames 90, 40, 40 -> no event (one miss < RELEASE_FRAMES); later release reports dur including both trailing 40s.
- Frames 40, 40, 90, 90, 90 -> only note_on bin 90. Also 4095 ×3 -> no event.
- STABLE_FRAMES = 1: active 40, frames 70, 70 -> note_off(40) on cycle N+1, then note_on(70) on cycle N+2, both single-cycle.

Source files
------------

// File: rtl/note_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : note_tracker
// Description : Debounces per-frame dominant FFT bins into note_on/note_off
//               events. note_off reports the held duration in frames.
//               Optional macro NOTE_TRACKER_HOLD_OUT_EN adds registered
//               current-note outputs (note_active_out, note_bin_out).
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module note_tracker #(
  parameter int STABLE_FRAMES  = 3,
  parameter int RELEASE_FRAMES = 2,
  parameter int BIN_TOL        = 1,
  parameter int MIN_BIN        = 2,
  parameter int MAX_BIN        = 299
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [11:0] peak_in,
  input  logic        peak_valid_in,
  output logic        event_valid_out,
  output logic        event_type_out,
  output logic [11:0] event_bin_out,
  output logic [15:0] event_dur_out
`ifdef NOTE_TRACKER_HOLD_OUT_EN
  ,
  output logic        note_active_out,
  output logic [11:0] note_bin_out
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAND   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic        typ;   // 1 = note_on, 0 = note_off
    logic [11:0] bin;
    logic [15:0] dur;
  } event_t;

  // Events waiting behind the output register. Normally at most one (the
  // note_on that follows a same-frame note_off); the extra depth covers
  // strobes arriving on consecutive cycles.
  localparam int QDEPTH = 4;

  function automatic logic is_silent(input logic [11:0] b);
    return (int'(b) < MIN_BIN) || (int'(b) > MAX_BIN);
  endfunction

  function automatic logic is_match(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] d;
    d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return int'(d) <= BIN_TOL;
  endfunction

  state_t      state, state_n;
  logic [11:0] cand_bin, cand_bin_n;
  logic [15:0] cand_cnt, cand_cnt_n;
  logic [11:0] act_bin, act_bin_n;
  logic [15:0] dur, dur_n;
  logic [15:0] miss_cnt, miss_cnt_n;

  event_t      q [QDEPTH];
  event_t      q_n [QDEPTH];
  logic [2:0]  q_cnt, q_cnt_n;

  event_t      ev0, ev1, out_n;
  logic [1:0]  n_new;
  logic        out_valid_n;
  event_t      all_ev [QDEPTH+2];
  logic [3:0]  total, rem;
  logic        silent;

  assign silent = is_silent(peak_in);

  // Next-state, note bookkeeping and new-event generation for this frame
  always_comb begin
    state_n    = state;
    cand_bin_n = cand_bin;
    cand_cnt_n = cand_cnt;
    act_bin_n  = act_bin;
    dur_n      = dur;
    miss_cnt_n = miss_cnt;
    n_new      = 2'd0;
    ev0        = '0;
    ev1        = '0;
    if (peak_valid_in) begin
      case (state)
        IDLE: begin
          if (!silent) begin
            if (STABLE_FRAMES == 1) begin
              state_n    = ACTIVE;
              act_bin_n  = peak_in;
              dur_n      = 16'd1;
              miss_cnt_n = 16'd0;
              ev0        = '{typ: 1'b1, bin: peak_in, dur: 16'd0};
              n_new      = 2'd1;
            end else begin
              state_n    = CAND;
              cand_bin_n = peak_in;
              cand_cnt_n = 16'd1;
            end
          end
        end
        CAND: begin
          if (is_match(peak_in, cand_bin)) begin
            cand_cnt_n = cand_cnt + 16'd1;
            if (cand_cnt + 16'd1 >= 16'(STABLE_FRAMES)) begin
              state_n    = ACTIVE;
              act_bin_n  = cand_bin;
              dur_n      = 16'(STABLE_FRAMES);
              miss_cnt_n = 16'd0;
              ev0        = '{typ: 1'b1, bin: cand_bin, dur: 16'd0};
              n_new      = 2'd1;
            end
          end else if (!silent) begin
            cand_bin_n = peak_in;
            cand_cnt_n = 16'd1;
          end else begin
            state_n = IDLE;
          end
        end
        ACTIVE: begin
          if (is_match(peak_in, act_bin)) begin
            dur_n      = (dur == 16'hFFFF) ? dur : dur + 16'd1;
            miss_cnt_n = 16'd0;
          end else begin
            miss_cnt_n = miss_cnt + 16'd1;
            if (miss_cnt + 16'd1 >= 16'(RELEASE_FRAMES)) begin
              ev0        = '{typ: 1'b0, bin: act_bin, dur: dur};
              n_new      = 2'd1;
              miss_cnt_n = 16'd0;
              if (silent) begin
                state_n = IDLE;
              end else if (STABLE_FRAMES == 1) begin
                // Release and re-acquire in one frame: note_on queues behind
                act_bin_n = peak_in;
                dur_n     = 16'd1;
                ev1       = '{typ: 1'b1, bin: peak_in, dur: 16'd0};
                n_new     = 2'd2;
              end else begin
                state_n    = CAND;
                cand_bin_n = peak_in;
                cand_cnt_n = 16'd1;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Merge queued and new events in order; the head goes to the output
  always_comb begin
    for (int i = 0; i < QDEPTH + 2; i++) all_ev[i] = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (i < int'(q_cnt)) all_ev[i] = q[i];
    end
    if (n_new != 2'd0) all_ev[q_cnt] = ev0;
    if (n_new == 2'd2) all_ev[q_cnt + 3'd1] = ev1;
    total       = {1'b0, q_cnt} + {2'b00, n_new};
    rem         = total - 4'd1;
    out_valid_n = (total != 4'd0);
    out_n       = out_valid_n ? all_ev[0] : '0;
    for (int i = 0; i < QDEPTH; i++) q_n[i] = all_ev[i+1];
    if (total == 4'd0)            q_cnt_n = 3'd0;
    else if (rem > 4'(QDEPTH))    q_cnt_n = 3'(QDEPTH);
    else                          q_cnt_n = rem[2:0];
  end

  // State, counters, event queue and registered event outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      cand_bin        <= 12'd0;
      cand_cnt        <= 16'd0;
      act_bin         <= 12'd0;
      dur             <= 16'd0;
      miss_cnt        <= 16'd0;
      q_cnt           <= 3'd0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= '0;
      event_valid_out <= 1'b0;
      event_type_out  <= 1'b0;
      event_bin_out   <= 12'd0;
      event_dur_out   <= 16'd0;
    end else begin
      state           <= state_n;
      cand_bin        <= cand_bin_n;
      cand_cnt        <= cand_cnt_n;
      act_bin         <= act_bin_n;
      dur             <= dur_n;
      miss_cnt        <= miss_cnt_n;
      q_cnt           <= q_cnt_n;
      for (int i = 0; i < QDEPTH; i++) q[i] <= q_n[i];
      event_valid_out <= out_valid_n;
      event_type_out  <= out_n.typ;
      event_bin_out   <= out_n.bin;
      event_dur_out   <= out_n.dur;
    end
  end

`ifdef NOTE_TRACKER_HOLD_OUT_EN
  // Current-note view mirroring the registered state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      note_active_out <= 1'b0;
      note_bin_out    <= 12'd0;
    end else begin
      note_active_out <= (state_n == ACTIVE);
      note_bin_out    <= (state_n == ACTIVE) ? act_bin_n : 12'd0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_note_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_note_tracker
// Description : Self-checking bench for note_tracker (default parameters and
//               STABLE_FRAMES = 1), frame-level note model plus directed
//               literal expectations.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_note_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] peak = 12'd0;
  logic        pv = 1'b0;

  logic        ev_v [2];
  logic        ev_t [2];
  logic [11:0] ev_b [2];
  logic [15:0] ev_d [2];
`ifdef NOTE_TRACKER_HOLD_OUT_EN
  logic        na [2];
  logic [11:0] nb [2];
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  note_tracker dut0 (
    .clk_in(clk), .rst_in(rst), .peak_in(peak), .peak_valid_in(pv),
    .event_valid_out(ev_v[0]), .event_type_out(ev_t[0]),
    .event_bin_out(ev_b[0]), .event_dur_out(ev_d[0])
`ifdef NOTE_TRACKER_HOLD_OUT_EN
    , .note_active_out(na[0]), .note_bin_out(nb[0])
`endif
  );

  note_tracker #(.STABLE_FRAMES(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .peak_in(peak), .peak_valid_in(pv),
    .event_valid_out(ev_v[1]), .event_type_out(ev_t[1]),
    .event_bin_out(ev_b[1]), .event_dur_out(ev_d[1])
`ifdef NOTE_TRACKER_HOLD_OUT_EN
    , .note_active_out(na[1]), .note_bin_out(nb[1])
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame-level note model ----------------
  // mode: 0 silence, 1 candidate building, 2 note sounding
  int S [2] = '{3, 1};
  int mode [2], cb [2], cc [2], ab [2], dr [2], miss [2];
  logic [28:0] eq0 [$];
  logic [28:0] eq1 [$];
  logic [28:0] log0 [$];
  logic [28:0] log1 [$];
  int          lc0 [$];
  int          lc1 [$];

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic push(input int k, input bit typ, input int bin, input int d);
    if (k == 0) eq0.push_back({typ, 12'(bin), 16'(d)});
    else        eq1.push_back({typ, 12'(bin), 16'(d)});
  endtask

  task automatic start(input int k, input int p);
    if (S[k] == 1) begin
      mode[k] = 2; ab[k] = p; dr[k] = 1; miss[k] = 0;
      push(k, 1'b1, p, 0);
    end else begin
      mode[k] = 1; cb[k] = p; cc[k] = 1;
    end
  endtask

  task automatic step(input int k, input int p);
    bit sil;
    sil = (p < 2) || (p > 299);
    case (mode[k])
      0: if (!sil) start(k, p);
      1: begin
        if (absd(p, cb[k]) <= 1) begin
          cc[k]++;
          if (cc[k] >= S[k]) begin
            mode[k] = 2; ab[k] = cb[k]; dr[k] = S[k]; miss[k] = 0;
            push(k, 1'b1, cb[k], 0);
          end
        end else if (!sil) start(k, p);
        else mode[k] = 0;
      end
      default: begin
        if (absd(p, ab[k]) <= 1) begin
          if (dr[k] < 65535) dr[k]++;
          miss[k] = 0;
        end else begin
          miss[k]++;
          if (miss[k] >= 2) begin
            push(k, 1'b0, ab[k], dr[k]);
            if (!sil) start(k, p);
            else mode[k] = 0;
          end
        end
      end
    endcase
  endtask

  // ---------------- per-cycle compare ----------------
  logic [28:0] expv [2];
  bit          expval [2];

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mode[k] = 0; cb[k] = 0; cc[k] = 0; ab[k] = 0; dr[k] = 0; miss[k] = 0;
        if (k == 0) eq0.delete(); else eq1.delete();
      end else if (pv) begin
        step(k, int'(peak));
      end
      expval[k] = 1'b0;
      expv[k]   = '0;
      if (k == 0 && eq0.size() > 0) begin expval[k] = 1'b1; expv[k] = eq0.pop_front(); end
      if (k == 1 && eq1.size() > 0) begin expval[k] = 1'b1; expv[k] = eq1.pop_front(); end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d valid", k), ev_v[k], expval[k]);
      if (expval[k]) begin
        chk($sformatf("dut%0d type", k), ev_t[k], expv[k][28]);
        chk($sformatf("dut%0d bin", k), ev_b[k], expv[k][27:16]);
        chk($sformatf("dut%0d dur", k), ev_d[k], expv[k][15:0]);
      end
`ifdef NOTE_TRACKER_HOLD_OUT_EN
      chk($sformatf("dut%0d active", k), na[k], (mode[k] == 2));
      chk($sformatf("dut%0d note_bin", k), nb[k], (mode[k] == 2) ? ab[k] : 0);
`endif
    end
    if (ev_v[0]) begin log0.push_back({ev_t[0], ev_b[0], ev_d[0]}); lc0.push_back(cyc); end
    if (ev_v[1]) begin log1.push_back({ev_t[1], ev_b[1], ev_d[1]}); lc1.push_back(cyc); end
  end

  // ---------------- stimulus ----------------
  int strobe_cyc;

  task automatic clear_logs();
    log0.delete(); log1.delete(); lc0.delete(); lc1.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic frame(input int p);
    @(negedge clk);
    peak = 12'(p); pv = 1'b1; strobe_cyc = cyc + 1;
    @(negedge clk);
    pv = 1'b0; peak = 12'd0;
    repeat (2) @(negedge clk);
  endtask

  function automatic longint ev(input bit typ, input int bin, input int d);
    logic [28:0] e;
    e = {typ, 12'(bin), 16'(d)};
    return longint'(e);
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();

    // Asynchronous reset mid-cycle while a note_on is on the outputs
    frame(40); frame(40);
    @(negedge clk); peak = 12'd41; pv = 1'b1;
    @(posedge clk); #2;
    chk("pre-reset note_on visible", ev_v[0], 1);
    pv = 1'b0; peak = 12'd0;
    rst = 1'b1; #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async rst valid%0d", k), ev_v[k], 0);
      chk($sformatf("async rst type%0d", k), ev_t[k], 0);
      chk($sformatf("async rst bin%0d", k), ev_b[k], 0);
      chk($sformatf("async rst dur%0d", k), ev_d[k], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; clear_logs();
    frame(40); frame(40);
    chk("after reset 40x2 no event", log0.size(), 0);

    // 40,40,41 -> one note_on(40)
    do_reset();
    frame(40); frame(40); frame(41);
    chk("on count", log0.size(), 1);
    if (log0.size() >= 1) begin
      chk("on event", longint'(log0[0]), ev(1, 40, 0));
      chk("on timing", lc0[0], strobe_cyc);
    end
    // 40x5 then 0,0 -> note_off(40, 8)
    repeat (5) frame(40);
    frame(0); frame(0);
    chk("off count", log0.size(), 2);
    if (log0.size() >= 2) chk("off event dur8", longint'(log0[1]), ev(0, 40, 8));
    frame(50); frame(50);
    chk("idle after release", log0.size(), 2);

    // Single miss does not release; trailing matches count
    do_reset();
    frame(40); frame(40); frame(40); frame(90); frame(40); frame(40);
    chk("one miss no release", log0.size(), 1);
    frame(0); frame(0);
    chk("miss release count", log0.size(), 2);
    if (log0.size() >= 2) chk("miss release dur5", longint'(log0[1]), ev(0, 40, 5));

    // Candidate restart
    do_reset();
    frame(40); frame(40); frame(90); frame(90); frame(90);
    chk("restart count", log0.size(), 1);
    if (log0.size() >= 1) chk("restart on90", longint'(log0[0]), ev(1, 90, 0));

    // 4095 is silent
    do_reset();
    frame(4095); frame(4095); frame(4095);
    chk("4095 silent", log0.size(), 0);
    chk("4095 silent s1", log1.size(), 0);

    // Tolerance boundary: 40 vs 42 differ by 2
    do_reset();
    frame(40); frame(42); frame(42); frame(42);
    chk("tol count", log0.size(), 1);
    if (log0.size() >= 1) chk("tol on42", longint'(log0[0]), ev(1, 42, 0));

    // Range boundaries
    do_reset();
    frame(300); frame(300); frame(300); frame(1); frame(1); frame(1);
    chk("out of range silent", log0.size(), 0);
    frame(2); frame(2); frame(2);
    chk("min bin on count", log0.size(), 1);
    if (log0.size() >= 1) chk("min bin on", longint'(log0[0]), ev(1, 2, 0));
    do_reset();
    frame(299); frame(299); frame(299); frame(301); frame(301);
    chk("max bin count", log0.size(), 2);
    if (log0.size() >= 2) chk("max bin off", longint'(log0[1]), ev(0, 299, 3));

    // STABLE_FRAMES = 1: note_off then note_on on consecutive cycles
    do_reset();
    frame(40); frame(70); frame(70);
    chk("s1 count", log1.size(), 3);
    if (log1.size() >= 3) begin
      chk("s1 off40", longint'(log1[1]), ev(0, 40, 1));
      chk("s1 on70", longint'(log1[2]), ev(1, 70, 0));
      chk("s1 off timing", lc1[1], strobe_cyc);
      chk("s1 on timing", lc1[2], strobe_cyc + 1);
    end

    // Back-to-back strobes, model-checked
    do_reset();
    @(negedge clk);
    pv = 1'b1;
    foreach (S[i]) ;
    peak = 12'd40;  @(negedge clk);
    peak = 12'd70;  @(negedge clk);
    peak = 12'd70;  @(negedge clk);
    peak = 12'd100; @(negedge clk);
    peak = 12'd0;   @(negedge clk);
    pv = 1'b0;
    repeat (4) @(negedge clk);

    // Duration saturation
    do_reset();
    @(negedge clk);
    peak = 12'd40; pv = 1'b1;
    repeat (65540) @(negedge clk);
    pv = 1'b0; peak = 12'd0;
    frame(0); frame(0);
    chk("sat count", log0.size(), 2);
    if (log0.size() >= 2) chk("sat dur", longint'(log0[1]), ev(0, 40, 65535));

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
